axi4lite_mem_responder: RTL and testbench

// - AXI4-Lite responder (slave) backed by an internal word-addressed RAM.
// - Serves as the memory end of the picorv32_axi mem_axi_* bus, for synthesis

---
 rtl/axi4lite_mem_responder.sv | 194 +++++++++++++++++++
 tb/tb_axi4lite_mem_responder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_mem_responder.sv
// AXI4-Lite memory responder: word-addressed RAM with independent read and write
// channels, one outstanding transaction per direction and programmable response latency.
module axi4lite_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata
);

  localparam int          AW    = $clog2(MEM_WORDS);
  localparam logic [7:0]  LAT   = 8'(LATENCY);
  localparam logic [29:0] DEPTH = 30'(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

  logic [31:0] r_mem [MEM_WORDS];

  wstate_t     r_wstate;
  logic        r_aw_held;
  logic        r_w_held;
  logic [AW-1:0] r_awidx;
  logic        r_aw_inrange;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [7:0]  r_wcnt;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;

  rstate_t     r_rstate;
  logic [AW-1:0] r_aridx;
  logic        r_ar_inrange;
  logic [7:0]  r_rcnt;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic w_aw_fire;
  logic w_w_fire;
  logic w_ar_fire;
  logic w_aw_now;
  logic w_w_now;
  logic w_commit;
  logic w_unused;

  assign w_aw_fire = mem_axi_awvalid & r_awready;
  assign w_w_fire  = mem_axi_wvalid & r_wready;
  assign w_ar_fire = mem_axi_arvalid & r_arready;
  assign w_aw_now  = r_aw_held | w_aw_fire;
  assign w_w_now   = r_w_held | w_w_fire;
  assign w_commit  = (r_wstate == W_WAIT) && (r_wcnt == 8'd0) && r_aw_inrange;
  assign w_unused  = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_awaddr[1:0], mem_axi_araddr[1:0]};

  assign mem_axi_awready = r_awready;
  assign mem_axi_wready  = r_wready;
  assign mem_axi_bvalid  = r_bvalid;
  assign mem_axi_arready = r_arready;
  assign mem_axi_rvalid  = r_rvalid;
  assign mem_axi_rdata   = r_rdata;

  // RAM has no reset so its contents survive resetn; commit is gated by registered state only.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) begin
          r_mem[r_awidx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate     <= W_IDLE;
      r_aw_held    <= 1'b0;
      r_w_held     <= 1'b0;
      r_awidx      <= '0;
      r_aw_inrange <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_wcnt       <= '0;
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_bvalid     <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_fire) begin
            r_aw_held    <= 1'b1;
            r_awidx      <= mem_axi_awaddr[AW+1:2];
            r_aw_inrange <= (mem_axi_awaddr[31:2] < DEPTH);
          end
          if (w_w_fire) begin
            r_w_held <= 1'b1;
            r_wdata  <= mem_axi_wdata;
            r_wstrb  <= mem_axi_wstrb;
          end
          // Entering W_WAIT on the later handshake edge gives bvalid one cycle later at LATENCY=0.
          if (w_aw_now && w_w_now) begin
            r_wstate  <= W_WAIT;
            r_wcnt    <= LAT;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
          end else begin
            r_awready <= !w_aw_now;
            r_wready  <= !w_w_now;
          end
        end
        W_WAIT: begin
          if (r_wcnt == 8'd0) begin
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
          end else begin
            r_wcnt <= r_wcnt - 8'd1;
          end
        end
        W_RESP: begin
          if (mem_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate     <= R_IDLE;
      r_aridx      <= '0;
      r_ar_inrange <= 1'b0;
      r_rcnt       <= '0;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_fire) begin
            r_aridx      <= mem_axi_araddr[AW+1:2];
            r_ar_inrange <= (mem_axi_araddr[31:2] < DEPTH);
            r_rcnt       <= LAT;
            r_arready    <= 1'b0;
            r_rstate     <= R_WAIT;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_rcnt == 8'd0) begin
            r_rdata  <= r_ar_inrange ? r_mem[r_aridx] : 32'd0;
            r_rvalid <= 1'b1;
            r_rstate <= R_RESP;
          end else begin
            r_rcnt <= r_rcnt - 8'd1;
          end
        end
        R_RESP: begin
          if (mem_axi_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_mem_responder.sv
// Bench for axi4lite_mem_responder: two instances (LATENCY 0 and 3) share one stimulus
// driver selected by sel, checked against a word-array memory model with cycle timing rules.
`timescale 1ns/1ps
module tb_axi4lite_mem_responder;

  localparam int MW_A  = 1024;
  localparam int MW_B  = 16;
  localparam int LAT_A = 0;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic [2:0]  prot = 3'd0;

  logic a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] rdata;

  assign awready = sel ? b_awready : a_awready;
  assign wready  = sel ? b_wready  : a_wready;
  assign bvalid  = sel ? b_bvalid  : a_bvalid;
  assign arready = sel ? b_arready : a_arready;
  assign rvalid  = sel ? b_rvalid  : a_rvalid;
  assign rdata   = sel ? b_rdata   : a_rdata;

  axi4lite_mem_responder #(.MEM_WORDS(MW_A), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid & ~sel), .mem_axi_awready(a_awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(prot),
    .mem_axi_wvalid(wvalid & ~sel), .mem_axi_wready(a_wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(a_bvalid), .mem_axi_bready(bready & ~sel),
    .mem_axi_arvalid(arvalid & ~sel), .mem_axi_arready(a_arready), .mem_axi_araddr(araddr), .mem_axi_arprot(prot),
    .mem_axi_rvalid(a_rvalid), .mem_axi_rready(rready & ~sel), .mem_axi_rdata(a_rdata)
  );

  axi4lite_mem_responder #(.MEM_WORDS(MW_B), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid & sel), .mem_axi_awready(b_awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(prot),
    .mem_axi_wvalid(wvalid & sel), .mem_axi_wready(b_wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(b_bvalid), .mem_axi_bready(bready & sel),
    .mem_axi_arvalid(arvalid & sel), .mem_axi_arready(b_arready), .mem_axi_araddr(araddr), .mem_axi_arprot(prot),
    .mem_axi_rvalid(b_rvalid), .mem_axi_rready(rready & sel), .mem_axi_rdata(b_rdata)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference memories plus a one-entry log of the latest commit, so a read sampled
  // on the very edge of a commit can be given the pre-write word.
  logic [31:0] mem_a [MW_A];
  logic [31:0] mem_b [MW_B];
  int          log_edge = -1;
  int          log_idx  = 0;
  logic        log_sel  = 1'b0;
  logic [31:0] log_old  = '0;

  function automatic int words();
    return sel ? MW_B : MW_A;
  endfunction

  function automatic bit in_range(input logic [31:0] addr);
    return ({2'b00, addr[31:2]} < 32'(words()));
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    if (!in_range(addr)) return 32'd0;
    return sel ? mem_b[int'(addr[31:2])] : mem_a[int'(addr[31:2])];
  endfunction

  task automatic model_commit(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] w;
    if (in_range(addr)) begin
      w = model_rd(addr);
      log_old = w; log_idx = int'(addr[31:2]); log_sel = sel; log_edge = edge_n;
      for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
      if (sel) mem_b[int'(addr[31:2])] = w; else mem_a[int'(addr[31:2])] = w;
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int bhold);
    int e = 0, hs_e = -1, seen = 0, lat;
    bit aw_d = 0, w_d = 0, done = 0, fa, fw, fb, exp_bv;
    lat = sel ? LAT_B : LAT_A;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!done && e < 300) begin
      exp_bv = (hs_e >= 0) && (e >= hs_e + lat + 1);
      checks += 3;
      if (awready !== ~aw_d) begin errors++; $display("FAIL wr_awready addr=%h e=%0d got=%b exp=%b", addr, e, awready, ~aw_d); end
      if (wready !== ~w_d) begin errors++; $display("FAIL wr_wready addr=%h e=%0d got=%b exp=%b", addr, e, wready, ~w_d); end
      if (bvalid !== exp_bv) begin errors++; $display("FAIL wr_bvalid addr=%h e=%0d got=%b exp=%b", addr, e, bvalid, exp_bv); end
      if (bvalid === 1'b1) begin
        if (seen == 0) model_commit(addr, data, strb);
        seen++;
      end
      awvalid = !aw_d && (e >= aw_dly);
      wvalid  = !w_d && (e >= w_dly);
      bready  = (bvalid === 1'b1) && (seen > bhold);
      fa = ((awvalid & awready) === 1'b1);
      fw = ((wvalid & wready) === 1'b1);
      fb = ((bvalid & bready) === 1'b1);
      @(posedge clk); #1; e++;
      if (fa) aw_d = 1;
      if (fw) w_d = 1;
      if ((fa || fw) && aw_d && w_d && hs_e < 0) hs_e = e;
      if (fb) done = 1;
    end
    awvalid = 0; wvalid = 0; bready = 0;
    if (!done) begin checks++; errors++; $display("FAIL wr_timeout addr=%h got=no_bresp exp=bresp", addr); end
    $display("write sel=%0d addr=%h data=%h strb=%h aw_dly=%0d w_dly=%0d bhold=%0d", sel, addr, data, strb, aw_dly, w_dly, bhold);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int rhold, output logic [31:0] got);
    int e = 0, ar_e = -1, seen = 0, lat;
    bit done = 0, far, fr, exp_rv, exp_ar;
    logic [31:0] exp_d;
    lat = sel ? LAT_B : LAT_A;
    got = 32'hx; exp_d = 32'hx;
    araddr = addr;
    while (!done && e < 300) begin
      exp_ar = (ar_e < 0);
      exp_rv = (ar_e >= 0) && (e >= ar_e + lat + 1);
      checks += 2;
      if (arready !== exp_ar) begin errors++; $display("FAIL rd_arready addr=%h e=%0d got=%b exp=%b", addr, e, arready, exp_ar); end
      if (rvalid !== exp_rv) begin errors++; $display("FAIL rd_rvalid addr=%h e=%0d got=%b exp=%b", addr, e, rvalid, exp_rv); end
      if (rvalid === 1'b1) begin
        checks++;
        if (seen == 0) begin
          #1;
          if (log_edge == edge_n && log_sel == sel && in_range(addr) && log_idx == int'(addr[31:2])) exp_d = log_old;
          else exp_d = model_rd(addr);
          got = rdata;
          if (rdata !== exp_d) begin errors++; $display("FAIL rd_data addr=%h got=%h exp=%h", addr, rdata, exp_d); end
        end else if (rdata !== got) begin
          errors++; $display("FAIL rd_stable addr=%h got=%h exp=%h", addr, rdata, got);
        end
        seen++;
      end
      arvalid = (ar_e < 0) && (e >= ar_dly);
      rready  = (rvalid === 1'b1) && (seen > rhold);
      far = ((arvalid & arready) === 1'b1);
      fr  = ((rvalid & rready) === 1'b1);
      @(posedge clk); #1; e++;
      if (far) ar_e = e;
      if (fr) done = 1;
    end
    arvalid = 0; rready = 0;
    if (!done) begin checks++; errors++; $display("FAIL rd_timeout addr=%h got=no_rresp exp=rresp", addr); end
    $display("read  sel=%0d addr=%h data=%h ar_dly=%0d rhold=%0d", sel, addr, got, ar_dly, rhold);
  endtask

  function automatic logic [31:0] rand_addr();
    int win;
    win = sel ? MW_B : 32;
    if ($urandom_range(0, 7) == 0) return {30'($urandom_range(words(), words() + 64)), 2'($urandom)};
    return {30'($urandom_range(0, win - 1)), 2'($urandom)};
  endfunction

  task automatic test_reset();
    resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if ({a_awready, a_wready, a_arready, a_bvalid, a_rvalid} !== 5'b0) begin errors++; $display("FAIL reset_ctl_a got=%b exp=00000", {a_awready, a_wready, a_arready, a_bvalid, a_rvalid}); end
    if ({b_awready, b_wready, b_arready, b_bvalid, b_rvalid} !== 5'b0) begin errors++; $display("FAIL reset_ctl_b got=%b exp=00000", {b_awready, b_wready, b_arready, b_bvalid, b_rvalid}); end
    if (a_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata_a got=%h exp=0", a_rdata); end
    if (b_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata_b got=%h exp=0", b_rdata); end
    resetn = 1;
    #1;
    checks++;
    if ({a_awready, a_wready, a_arready} !== 3'b000) begin errors++; $display("FAIL ready_before_edge got=%b exp=000", {a_awready, a_wready, a_arready}); end
    @(posedge clk); #1;
    checks += 2;
    if ({a_awready, a_wready, a_arready} !== 3'b111) begin errors++; $display("FAIL ready_after_reset_a got=%b exp=111", {a_awready, a_wready, a_arready}); end
    if ({b_awready, b_wready, b_arready} !== 3'b111) begin errors++; $display("FAIL ready_after_reset_b got=%b exp=111", {b_awready, b_wready, b_arready}); end
    $display("reset released");
  endtask

  task automatic test_init();
    sel = 0;
    for (int i = 0; i < 32; i++) axi_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0);
    sel = 1;
    for (int i = 0; i < MW_B; i++) axi_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0);
  endtask

  task automatic test_write_read();
    logic [31:0] got;
    sel = 0;
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(32'h10, 0, 0, got);
    checks++;
    if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL full_word got=%h exp=deadbeef", got); end
    axi_write(32'h10, 32'h000000AA, 4'h1, 0, 0, 0);
    axi_read(32'h10, 0, 0, got);
    checks++;
    if (got !== 32'hDEADBEAA) begin errors++; $display("FAIL byte_strobe got=%h exp=deadbeaa", got); end
  endtask

  task automatic test_w_before_aw();
    sel = 0;
    axi_write(32'h20, 32'h12345678, 4'hF, 3, 0, 5);
    axi_write(32'h24, 32'h9ABCDEF0, 4'hF, 0, 2, 2);
  endtask

  task automatic test_latency();
    logic [31:0] got;
    sel = 1;
    axi_read(32'h4, 0, 0, got);
    axi_read(32'h4, 1, 4, got);
  endtask

  task automatic test_out_of_range();
    logic [31:0] got, old0;
    sel = 0;
    old0 = mem_a[0];
    axi_read(32'(4 * MW_A), 0, 0, got);
    checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL oor_read got=%h exp=0", got); end
    axi_write(32'(4 * MW_A), 32'hCAFEF00D, 4'hF, 0, 0, 0);
    axi_read(32'h0, 0, 0, got);
    checks++;
    if (got !== old0) begin errors++; $display("FAIL oor_alias got=%h exp=%h", got, old0); end
    sel = 1;
    axi_read(32'(4 * MW_B + 8), 0, 1, got);
  endtask

  task automatic test_simultaneous();
    logic [31:0] got, old, nw;
    sel = 0;
    old = mem_a[12];
    nw = ~old;
    fork
      axi_write(32'h30, nw, 4'hF, 0, 0, 0);
      axi_read(32'h30, 0, 0, got);
    join
    checks++;
    if (got !== old) begin errors++; $display("FAIL same_edge_old got=%h exp=%h", got, old); end
    axi_read(32'h30, 0, 0, got);
    checks++;
    if (got !== nw) begin errors++; $display("FAIL same_edge_new got=%h exp=%h", got, nw); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] got, old;
    sel = 1;
    old = mem_b[5];
    awaddr = 32'h14; wdata = ~old; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    checks++;
    if ({b_awready, b_wready} !== 2'b00) begin errors++; $display("FAIL rw_accepted got=%b exp=00", {b_awready, b_wready}); end
    @(posedge clk); #1;
    resetn = 0;
    #1;
    checks += 2;
    if ({b_awready, b_wready, b_arready, b_bvalid, b_rvalid} !== 5'b0) begin errors++; $display("FAIL rw_async got=%b exp=00000", {b_awready, b_wready, b_arready, b_bvalid, b_rvalid}); end
    if (b_rdata !== 32'd0) begin errors++; $display("FAIL rw_rdata got=%h exp=0", b_rdata); end
    repeat (4) @(posedge clk);
    #1;
    resetn = 1;
    @(posedge clk); #1;
    checks++;
    if ({b_awready, b_wready, b_arready} !== 3'b111) begin errors++; $display("FAIL rw_ready got=%b exp=111", {b_awready, b_wready, b_arready}); end
    axi_read(32'h14, 0, 0, got);
    checks++;
    if (got !== old) begin errors++; $display("FAIL rw_no_commit got=%h exp=%h", got, old); end
  endtask

  task automatic test_random(input logic s, input int n);
    logic [31:0] got;
    sel = s;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0: axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        1: axi_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3), got);
        default: fork
          axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
          axi_read(rand_addr(), $urandom_range(0, 2), $urandom_range(0, 2), got);
        join
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_w_before_aw();
    test_latency();
    test_out_of_range();
    test_simultaneous();
    test_reset_in_wait();
    test_random(1'b0, 80);
    test_random(1'b1, 80);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
